tb_stream_fifo: RTL

- Synchronous valid/ready streaming FIFO. It is the DUT that the template's driver stimulates with sequence items and that the monitor observes.
- Accepts data beats with a last-of-packet flag on a slave port and presents them in order on a master port.
- Reports fill level and a running count of completed output packets, giving the scoreboard checkable state.

---
 rtl/tb_dut_pkg.sv | 14 +
 rtl/tb_fifo_ram.sv | 28 ++
 rtl/tb_stream_fifo.sv | 112 +++++++++++
 3 files changed

// File: rtl/tb_dut_pkg.sv
// Shared defaults and beat payload type for the streaming FIFO.
package tb_dut_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 8;
  localparam int unsigned CNT_W_DEF  = 16;

  // Default-width beat payload; storage packs it as {data, last}.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic                  last;
  } beat_t;

endpackage : tb_dut_pkg

// File: rtl/tb_fifo_ram.sv
// FIFO storage: synchronous write, asynchronous read, no reset on the array.
module tb_fifo_ram
  import tb_dut_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       i_we,
  input  logic [$clog2(DEPTH)-1:0]   i_waddr,
  input  logic [DATA_W:0]            i_wdata,
  input  logic [$clog2(DEPTH)-1:0]   i_raddr,
  output logic [DATA_W:0]            o_rdata_c
);

  logic [DATA_W:0] r_mem [DEPTH];

  // Write one entry per enabled edge.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Head entry is visible in the same cycle the read pointer moves.
  assign o_rdata_c = r_mem[i_raddr];

endmodule : tb_fifo_ram

// File: rtl/tb_stream_fifo.sv
// Valid/ready streaming FIFO with fill level and completed-packet counter.
module tb_stream_fifo
  import tb_dut_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_W-1:0]        m_data,
  output logic                     m_last,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         pkt_count
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;

  // Reject unsupported geometries at elaboration.
  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("tb_stream_fifo: DEPTH must be a power of 2 and >= 2");
    end
    if (DATA_W < 1) begin : g_bad_width
      $error("tb_stream_fifo: DATA_W must be >= 1");
    end
  endgenerate

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_level;
  logic              r_m_valid;
  logic              r_s_ready;
  logic [CNT_W-1:0]  r_pkt_count;

  logic [PTR_W-1:0]  w_wr_nxt;
  logic [PTR_W-1:0]  w_rd_nxt;
  logic              w_push;
  logic              w_pop;
  logic              w_full_nxt;
  logic              w_empty_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [DATA_W:0]   w_rdata;

  tb_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk       (clk),
    .i_we      (w_push & ~rst),
    .i_waddr   (r_wr_ptr[ADDR_W-1:0]),
    .i_wdata   ({s_data, s_last}),
    .i_raddr   (r_rd_ptr[ADDR_W-1:0]),
    .o_rdata_c (w_rdata)
  );

  // Handshakes, next pointers and next flags; flush overrides both directions.
  always_comb begin
    w_push   = s_valid & r_s_ready & ~flush;
    w_pop    = r_m_valid & m_ready & ~flush;
    w_wr_nxt = r_wr_ptr;
    w_rd_nxt = r_rd_ptr;
    if (flush) begin
      w_rd_nxt = r_wr_ptr;
    end else begin
      if (w_push) w_wr_nxt = r_wr_ptr + PTR_W'(1);
      if (w_pop)  w_rd_nxt = r_rd_ptr + PTR_W'(1);
    end
    w_empty_nxt = (w_wr_nxt == w_rd_nxt);
    w_full_nxt  = (w_wr_nxt[ADDR_W] != w_rd_nxt[ADDR_W]) &&
                  (w_wr_nxt[ADDR_W-1:0] == w_rd_nxt[ADDR_W-1:0]);
    w_cnt_nxt   = r_pkt_count;
    if (w_pop && w_rdata[0]) begin
      w_cnt_nxt = r_pkt_count + CNT_W'(1);
    end
  end

  // State registers; reset wins over flush and any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_m_valid   <= 1'b0;
      r_s_ready   <= 1'b0;
      r_pkt_count <= '0;
    end else begin
      r_wr_ptr    <= w_wr_nxt;
      r_rd_ptr    <= w_rd_nxt;
      r_level     <= w_wr_nxt - w_rd_nxt;
      r_m_valid   <= ~w_empty_nxt;
      r_s_ready   <= ~w_full_nxt;
      r_pkt_count <= w_cnt_nxt;
    end
  end

  assign s_ready   = r_s_ready;
  assign m_valid   = r_m_valid;
  assign m_data    = w_rdata[DATA_W:1];
  assign m_last    = w_rdata[0];
  assign level     = r_level;
  assign pkt_count = r_pkt_count;

endmodule : tb_stream_fifo
